// File: rtl/tia_horizontal_pkg.sv
// Shared constants for the TIA horizontal counter: the 57-state LFSR sequence
// and the line positions the decoder reacts to.
package tia_horizontal_pkg;

  localparam int LINE_COUNTS = 57;

  typedef logic [5:0] lfsr_t;
  typedef logic [5:0] idx_t;
  typedef logic [0:LINE_COUNTS-1][5:0] lfsr_table_t;

  localparam idx_t IDX_LINE_START = 6'd0;
  localparam idx_t IDX_HSYNC_SET  = 6'd4;
  localparam idx_t IDX_CBURST_SET = 6'd8;
  localparam idx_t IDX_CBURST_CLR = 6'd12;
  localparam idx_t IDX_HBLANK_CLR = 6'd16;
  localparam idx_t IDX_HMOVE_CLR  = 6'd18;
  localparam idx_t IDX_SHB        = 6'd56;

  // XNOR feedback of the two low bits shifted in at the top; 111111 is the lockup state
  function automatic lfsr_t lfsr_next(input lfsr_t v);
    return {~(v[0] ^ v[1]), v[5:1]};
  endfunction

  function automatic lfsr_table_t build_lfsr_seq();
    lfsr_table_t t;
    lfsr_t       v;
    v = '0;
    t = '0;
    for (int n = 0; n < LINE_COUNTS; n++) begin
      t[n] = v;
      v    = lfsr_next(v);
    end
    return t;
  endfunction

  localparam lfsr_table_t LFSR_SEQ = build_lfsr_seq();

endpackage

// File: rtl/tia_horizontal_decode_if.sv
// Strobes and levels exchanged between the horizontal counter/CPU side (master)
// and the horizontal decoder (slave).
interface tia_horizontal_decode_if;
  import tia_horizontal_pkg::*;

  logic  hclk_en;
  lfsr_t lfsr_out;
  logic  wsync_req;
  logic  hmove_req;
  logic  shb;
  logic  hsync;
  logic  hblank;
  logic  cburst;
  logic  rdy;
  logic  line_start;
  logic  seq_err;

  modport master (
    output hclk_en, lfsr_out, wsync_req, hmove_req,
    input  shb, hsync, hblank, cburst, rdy, line_start, seq_err
  );

  modport slave (
    input  hclk_en, lfsr_out, wsync_req, hmove_req,
    output shb, hsync, hblank, cburst, rdy, line_start, seq_err
  );

endinterface

// File: rtl/tia_lfsr_index.sv
// Maps an LFSR value back to its position in the line; values outside the
// sequence (such as 111111) map to position 0.
module tia_lfsr_index
  import tia_horizontal_pkg::*;
(
  input  lfsr_t i_value,
  output idx_t  o_index
);

  always_comb begin
    o_index = '0;
    for (int n = 0; n < LINE_COUNTS; n++) begin
      if (LFSR_SEQ[n] == i_value) o_index = idx_t'(n);
    end
  end

endmodule

// File: rtl/tia_horizontal_decode.sv
// Tracks the horizontal LFSR position and decodes sync, blank, colour burst,
// end-of-line reset and the WSYNC CPU stall from it.
module tia_horizontal_decode
  import tia_horizontal_pkg::*;
(
  input  logic                   clk,
  input  logic                   rl,
  tia_horizontal_decode_if.slave bus
);

  idx_t r_idx;
  logic r_started;
  logic r_hmove_lat;
  logic r_shb;
  logic r_hsync;
  logic r_hblank;
  logic r_cburst;
  logic r_rdy;
  logic r_line_start;
  logic r_seq_err;

  idx_t w_idx_inc;
  idx_t w_idx_expect;
  idx_t w_idx_lookup;
  idx_t w_idx_new;
  logic w_match;
  logic w_hsync_level;
  logic w_cburst_level;
  logic w_hblank_level;

  tia_lfsr_index u_index (
    .i_value (bus.lfsr_out),
    .o_index (w_idx_lookup)
  );

  // The first count after reset must be 000000, so expect position 0 until then
  always_comb begin
    w_idx_inc      = (r_idx >= idx_t'(LINE_COUNTS - 1)) ? '0 : r_idx + 6'd1;
    w_idx_expect   = r_started ? w_idx_inc : IDX_LINE_START;
    w_match        = (bus.lfsr_out == LFSR_SEQ[w_idx_expect]);
    w_idx_new      = w_match ? w_idx_expect : w_idx_lookup;
    w_hsync_level  = (w_idx_new >= IDX_HSYNC_SET) && (w_idx_new < IDX_CBURST_SET);
    w_cburst_level = (w_idx_new >= IDX_CBURST_SET) && (w_idx_new < IDX_CBURST_CLR);
    w_hblank_level = (w_idx_new < IDX_HBLANK_CLR) ||
                     (r_hmove_lat && (w_idx_new < IDX_HMOVE_CLR));
  end

  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      r_idx        <= '0;
      r_started    <= 1'b0;
      r_hmove_lat  <= 1'b0;
      r_shb        <= 1'b0;
      r_hsync      <= 1'b0;
      r_hblank     <= 1'b1;
      r_cburst     <= 1'b0;
      r_rdy        <= 1'b1;
      r_line_start <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_shb        <= 1'b0;
      r_line_start <= 1'b0;
      if (bus.hclk_en) begin
        r_idx     <= w_idx_new;
        r_started <= 1'b1;
        if (w_match) begin
          case (w_idx_new)
            IDX_LINE_START: begin
              r_hblank <= 1'b1;
              r_hsync  <= 1'b0;
              r_cburst <= 1'b0;
            end
            IDX_HSYNC_SET: r_hsync <= 1'b1;
            IDX_CBURST_SET: begin
              r_hsync  <= 1'b0;
              r_cburst <= 1'b1;
            end
            IDX_CBURST_CLR: r_cburst <= 1'b0;
            IDX_HBLANK_CLR: if (!r_hmove_lat) r_hblank <= 1'b0;
            IDX_HMOVE_CLR:  if (r_hmove_lat) r_hblank <= 1'b0;
            default: ;
          endcase
        end else begin
          // After a jump the edge-based decode is meaningless; rebuild levels from position
          r_seq_err <= 1'b1;
          r_hsync   <= w_hsync_level;
          r_cburst  <= w_cburst_level;
          r_hblank  <= w_hblank_level;
        end
        if (w_idx_new == IDX_LINE_START) begin
          r_line_start <= 1'b1;
          r_rdy        <= 1'b1;
        end
        if (w_idx_new == IDX_SHB) r_shb <= 1'b1;
        if (w_idx_new == IDX_HMOVE_CLR) r_hmove_lat <= 1'b0;
      end
      // Requests come last so they win over a release or clear on the same edge
      if (bus.wsync_req) r_rdy <= 1'b0;
      if (bus.hmove_req) r_hmove_lat <= 1'b1;
    end
  end

  assign bus.shb        = r_shb;
  assign bus.hsync      = r_hsync;
  assign bus.hblank     = r_hblank;
  assign bus.cburst     = r_cburst;
  assign bus.rdy        = r_rdy;
  assign bus.line_start = r_line_start;
  assign bus.seq_err    = r_seq_err;

endmodule

// File: tb/tb_tia_horizontal_decode.sv
// Directed bench for tia_horizontal_decode: normal lines, HMOVE, WSYNC,
// sequence errors and asynchronous reset.
module tb_tia_horizontal_decode;

  logic clk;
  logic rl;
  int   checks;
  int   errors;

  tia_horizontal_decode_if bus ();

  tia_horizontal_decode dut (
    .clk (clk),
    .rl  (rl),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LFSR value n steps after 000000 with XNOR(b0,b1) shifted in at the top
  function automatic logic [5:0] seqVal(input int n);
    logic [5:0] v;
    v = 6'b000000;
    for (int k = 0; k < n; k++) v = {~(v[0] ^ v[1]), v[5:1]};
    return v;
  endfunction

  // Three idle clocks, then one clock with hclk_en high; returns 1 time unit after the sampling edge
  task automatic hclk(input logic [5:0] val, input logic ws, input logic hm);
    repeat (3) @(posedge clk);
    #1;
    bus.hclk_en   = 1'b1;
    bus.lfsr_out  = val;
    bus.wsync_req = ws;
    bus.hmove_req = hm;
    @(posedge clk);
    #1;
    bus.hclk_en   = 1'b0;
    bus.wsync_req = 1'b0;
    bus.hmove_req = 1'b0;
  endtask

  task automatic doReset();
    rl = 1'b0;
    bus.hclk_en = 1'b0;
    bus.wsync_req = 1'b0;
    bus.hmove_req = 1'b0;
    bus.lfsr_out = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    rl = 1'b1;
  endtask

  task automatic test_reset();
    rl = 1'b1;
    bus.hclk_en = 1'b0;
    bus.wsync_req = 1'b0;
    bus.hmove_req = 1'b0;
    bus.lfsr_out = 6'b000000;
    #1;
    rl = 1'b0;
    #1;
    checks++; if (bus.hblank !== 1'b1) begin errors++; $display("[TB] FAIL reset_hblank got %b want 1", bus.hblank); end
    checks++; if (bus.hsync !== 1'b0) begin errors++; $display("[TB] FAIL reset_hsync got %b want 0", bus.hsync); end
    checks++; if (bus.cburst !== 1'b0) begin errors++; $display("[TB] FAIL reset_cburst got %b want 0", bus.cburst); end
    checks++; if (bus.rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy got %b want 1", bus.rdy); end
    checks++; if (bus.shb !== 1'b0) begin errors++; $display("[TB] FAIL reset_shb got %b want 0", bus.shb); end
    checks++; if (bus.line_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_line_start got %b want 0", bus.line_start); end
    checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_seq_err got %b want 0", bus.seq_err); end
    doReset();
  endtask

  task automatic test_normal_lines();
    time lastStart;
    logic expHsync, expCburst, expHblank;
    lastStart = 0;
    for (int line = 0; line < 2; line++) begin
      for (int n = 0; n < 57; n++) begin
        hclk(seqVal(n), 1'b0, 1'b0);
        expHsync  = (n >= 4) && (n < 8);
        expCburst = (n >= 8) && (n < 12);
        expHblank = (n < 16);
        checks++; if (bus.hsync !== expHsync) begin errors++; $display("[TB] FAIL line_hsync n=%0d got %b want %b", n, bus.hsync, expHsync); end
        checks++; if (bus.cburst !== expCburst) begin errors++; $display("[TB] FAIL line_cburst n=%0d got %b want %b", n, bus.cburst, expCburst); end
        checks++; if (bus.hblank !== expHblank) begin errors++; $display("[TB] FAIL line_hblank n=%0d got %b want %b", n, bus.hblank, expHblank); end
        checks++; if (bus.shb !== (n == 56)) begin errors++; $display("[TB] FAIL line_shb n=%0d got %b want %b", n, bus.shb, (n == 56)); end
        checks++; if (bus.line_start !== (n == 0)) begin errors++; $display("[TB] FAIL line_start n=%0d got %b want %b", n, bus.line_start, (n == 0)); end
        checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("[TB] FAIL line_seq_err n=%0d got %b want 0", n, bus.seq_err); end
        if (n == 0) begin
          if (line == 1) begin
            checks++;
            if ($time - lastStart != 2280) begin errors++; $display("[TB] FAIL line_period got %0t want 2280", $time - lastStart); end
          end
          lastStart = $time;
        end
      end
    end
  endtask

  task automatic test_hmove();
    for (int n = 0; n < 57; n++) begin
      hclk(seqVal(n), 1'b0, n == 10);
      checks++; if (bus.hblank !== (n < 18)) begin errors++; $display("[TB] FAIL hmove_hblank n=%0d got %b want %b", n, bus.hblank, (n < 18)); end
    end
    for (int n = 0; n < 57; n++) begin
      hclk(seqVal(n), 1'b0, 1'b0);
      checks++; if (bus.hblank !== (n < 16)) begin errors++; $display("[TB] FAIL nohmove_hblank n=%0d got %b want %b", n, bus.hblank, (n < 16)); end
    end
  endtask

  task automatic test_wsync();
    for (int n = 0; n < 57; n++) begin
      hclk(seqVal(n), n == 30, 1'b0);
      checks++; if (bus.rdy !== (n < 30)) begin errors++; $display("[TB] FAIL wsync_rdy n=%0d got %b want %b", n, bus.rdy, (n < 30)); end
    end
    for (int n = 0; n < 57; n++) begin
      hclk(seqVal(n), n == 0, 1'b0);
      checks++; if (bus.rdy !== 1'b0) begin errors++; $display("[TB] FAIL wsync_same_edge_rdy n=%0d got %b want 0", n, bus.rdy); end
    end
    for (int n = 0; n < 57; n++) begin
      hclk(seqVal(n), 1'b0, 1'b0);
      checks++; if (bus.rdy !== 1'b1) begin errors++; $display("[TB] FAIL wsync_release_rdy n=%0d got %b want 1", n, bus.rdy); end
    end
  endtask

  task automatic test_seq_err();
    for (int n = 0; n < 20; n++) hclk(seqVal(n), 1'b0, 1'b0);
    hclk(6'b111111, 1'b0, 1'b0);
    checks++; if (bus.seq_err !== 1'b1) begin errors++; $display("[TB] FAIL bad_value_seq_err got %b want 1", bus.seq_err); end
    checks++; if (bus.hblank !== 1'b1) begin errors++; $display("[TB] FAIL bad_value_hblank got %b want 1", bus.hblank); end
    checks++; if (bus.line_start !== 1'b1) begin errors++; $display("[TB] FAIL bad_value_line_start got %b want 1", bus.line_start); end
    for (int n = 1; n < 57; n++) begin
      hclk(seqVal(n), 1'b0, 1'b0);
      checks++; if (bus.hsync !== ((n >= 4) && (n < 8))) begin errors++; $display("[TB] FAIL resync_hsync n=%0d got %b want %b", n, bus.hsync, ((n >= 4) && (n < 8))); end
      checks++; if (bus.shb !== (n == 56)) begin errors++; $display("[TB] FAIL resync_shb n=%0d got %b want %b", n, bus.shb, (n == 56)); end
    end
    for (int n = 0; n < 57; n++) begin
      hclk(seqVal(n), 1'b0, 1'b0);
      checks++; if (bus.seq_err !== 1'b1) begin errors++; $display("[TB] FAIL sticky_seq_err n=%0d got %b want 1", n, bus.seq_err); end
    end
    #2;
    rl = 1'b0;
    #1;
    checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_clears_seq_err got %b want 0", bus.seq_err); end
    doReset();
  endtask

  task automatic test_skip();
    for (int n = 0; n < 6; n++) begin
      hclk(seqVal(n), 1'b0, 1'b0);
      checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_seq_err n=%0d got %b want 0", n, bus.seq_err); end
      checks++; if (bus.hsync !== (n >= 4)) begin errors++; $display("[TB] FAIL pre_skip_hsync n=%0d got %b want %b", n, bus.hsync, (n >= 4)); end
    end
    hclk(seqVal(9), 1'b0, 1'b0);
    checks++; if (bus.seq_err !== 1'b1) begin errors++; $display("[TB] FAIL skip_seq_err got %b want 1", bus.seq_err); end
    checks++; if (bus.hsync !== 1'b0) begin errors++; $display("[TB] FAIL skip_hsync got %b want 0", bus.hsync); end
    checks++; if (bus.cburst !== 1'b1) begin errors++; $display("[TB] FAIL skip_cburst got %b want 1", bus.cburst); end
    checks++; if (bus.hblank !== 1'b1) begin errors++; $display("[TB] FAIL skip_hblank got %b want 1", bus.hblank); end
    for (int n = 10; n < 57; n++) begin
      hclk(seqVal(n), 1'b0, 1'b0);
      checks++; if (bus.cburst !== (n < 12)) begin errors++; $display("[TB] FAIL post_skip_cburst n=%0d got %b want %b", n, bus.cburst, (n < 12)); end
      checks++; if (bus.shb !== (n == 56)) begin errors++; $display("[TB] FAIL post_skip_shb n=%0d got %b want %b", n, bus.shb, (n == 56)); end
    end
  endtask

  task automatic test_reset_wsync();
    for (int n = 0; n < 41; n++) hclk(seqVal(n), n == 40, 1'b0);
    checks++; if (bus.rdy !== 1'b0) begin errors++; $display("[TB] FAIL stall_rdy got %b want 0", bus.rdy); end
    checks++; if (bus.hblank !== 1'b0) begin errors++; $display("[TB] FAIL stall_hblank got %b want 0", bus.hblank); end
    #2;
    rl = 1'b0;
    #1;
    checks++; if (bus.rdy !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_rdy got %b want 1", bus.rdy); end
    checks++; if (bus.hblank !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_hblank got %b want 1", bus.hblank); end
    doReset();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal_lines();
    test_hmove();
    test_wsync();
    test_seq_err();
    test_skip();
    test_reset_wsync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
